pipe_hazard_ctrl: RTL and testbench

- Central sequencer for the IF/ID/EX/WB pipeline and its three buffers (IF_ID, ID_EX, EX_WB).
- Each cycle it drives the PC and buffer load-enables and flushes, covering:
  - power-up purge of the unreset buffers;
  - RAW-hazard stalls (this pipeline has no forwarding);
  - taken-branch squash;
  - freeze on multi-cycle data-memory access, with a watchdog.
- Also keeps saturating stall and flush event counters.

---
 rtl/pipe_ctrl_pkg.sv | 63 ++++++
 rtl/sat_counter.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared definitions for the IF/ID/EX/WB pipeline sequencer:
//   - sequencer state encoding (ST_INIT / ST_RUN / ST_MEM_WAIT / ST_MEM_ERR)
//   - the bubble/NOP instruction value loaded by a buffer flush
//   - default register-index width
//   - a packed bundle of the per-cycle pipeline control outputs, plus the
//     canned patterns the sequencer selects between
// ----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int REG_AW_DEF = 6;

  // A flushed buffer loads all-zero, which the decoder treats as a NOP.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_MEM_ERR  = 2'd3
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic pc_sel_branch;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_wb_en;
    logic ex_wb_flush;
  } ctrl_t;

  // Purge every buffer while the PC holds.
  localparam ctrl_t CTRL_INIT   = '{pc_en: 1'b0, pc_sel_branch: 1'b0,
                                    if_id_en: 1'b1, if_id_flush: 1'b1,
                                    id_ex_en: 1'b1, id_ex_flush: 1'b1,
                                    ex_wb_en: 1'b1, ex_wb_flush: 1'b1};
  // Normal flow: everything advances.
  localparam ctrl_t CTRL_FLOW   = '{pc_en: 1'b1, pc_sel_branch: 1'b0,
                                    if_id_en: 1'b1, if_id_flush: 1'b0,
                                    id_ex_en: 1'b1, id_ex_flush: 1'b0,
                                    ex_wb_en: 1'b1, ex_wb_flush: 1'b0};
  // Memory stall: front end frozen, WB receives a bubble.
  localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, pc_sel_branch: 1'b0,
                                    if_id_en: 1'b0, if_id_flush: 1'b0,
                                    id_ex_en: 1'b0, id_ex_flush: 1'b0,
                                    ex_wb_en: 1'b1, ex_wb_flush: 1'b1};
  // Taken branch: redirect PC and squash the two younger instructions.
  localparam ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, pc_sel_branch: 1'b1,
                                    if_id_en: 1'b1, if_id_flush: 1'b1,
                                    id_ex_en: 1'b1, id_ex_flush: 1'b1,
                                    ex_wb_en: 1'b1, ex_wb_flush: 1'b0};
  // RAW hazard: hold PC and IF_ID, insert a bubble into EX.
  localparam ctrl_t CTRL_HAZARD = '{pc_en: 1'b0, pc_sel_branch: 1'b0,
                                    if_id_en: 1'b0, if_id_flush: 1'b0,
                                    id_ex_en: 1'b1, id_ex_flush: 1'b1,
                                    ex_wb_en: 1'b1, ex_wb_flush: 1'b0};
  // Watchdog tripped: nothing moves until reset.
  localparam ctrl_t CTRL_HALT   = '0;

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   Event counter that increments by one per cycle while inc is high and
//   sticks at all-ones instead of wrapping.
//   Ports:
//     clk    in   clock
//     rst_n  in   asynchronous active-low reset (count -> 0)
//     inc    in   count this cycle
//     count  out  current count (registered)
// ----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central sequencer for a 4-stage IF/ID/EX/WB pipeline without forwarding.
//   Drives the PC and the IF_ID / ID_EX / EX_WB load-enables and flushes:
//   power-up purge, RAW-hazard stalls, taken-branch squash, and freezing
//   during multi-cycle data-memory accesses with a watchdog.
//   Ports:
//     clk, rst_n               clock, asynchronous active-low reset
//     id_rs/id_rt              source registers of the ID instruction
//     id_use_rs/id_use_rt      ID instruction actually reads rs/rt
//     ex_rd/ex_wr              EX destination and write flag
//     ex_branch_taken          EX resolved a taken branch/jump
//     ex_mem_req/mem_ready     EX data-memory access and its completion
//     wb_rd/wb_wr              WB destination and write flag
//     pc_en/pc_sel_branch      PC load and branch-target select
//     *_en/*_flush             buffer load-enables and bubble inserts
//     mem_err                  sticky watchdog error (registered)
//     stall_cnt/flush_cnt      saturating event counters (registered)
//   Enables and flushes are combinational from state and inputs.
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int INIT_CYCLES = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wr,
  input  logic              ex_branch_taken,
  input  logic              ex_mem_req,
  input  logic              mem_ready,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_wr,
  output logic              pc_en,
  output logic              pc_sel_branch,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_flush,
  output logic              ex_wb_en,
  output logic              ex_wb_flush,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  state_t        state;
  logic [IW-1:0] init_cnt;
  logic [WW-1:0] wait_cnt;

  logic  hazard_rs, hazard_rt, hazard;
  logic  mem_stall;
  logic  stall_inc, flush_inc;
  ctrl_t ctrl;

  // No forwarding: any in-flight writer of a source register is a hazard.
  // Register 0 is deliberately not special-cased.
  assign hazard_rs = id_use_rs && ((ex_wr && (ex_rd == id_rs)) ||
                                   (wb_wr && (wb_rd == id_rs)));
  assign hazard_rt = id_use_rt && ((ex_wr && (ex_rd == id_rt)) ||
                                   (wb_wr && (wb_rd == id_rt)));
  assign hazard    = hazard_rs || hazard_rt;

  // Starting or continuing an outstanding memory access this cycle.
  assign mem_stall = ((state == ST_RUN) && ex_mem_req && !mem_ready) ||
                     ((state == ST_MEM_WAIT) && !mem_ready);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    ctrl      = CTRL_FLOW;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    unique case (state)
      ST_INIT:    ctrl = CTRL_INIT;
      ST_MEM_ERR: ctrl = CTRL_HALT;
      default: begin
        // RUN and MEM_WAIT share one priority chain; the memory stall wins,
        // and a branch overrides a simultaneous hazard.
        if (mem_stall) begin
          ctrl      = CTRL_FREEZE;
          stall_inc = 1'b1;
        end else if (ex_branch_taken) begin
          ctrl      = CTRL_BRANCH;
          flush_inc = 1'b1;
        end else if (hazard) begin
          ctrl      = CTRL_HAZARD;
          stall_inc = 1'b1;
        end
      end
    endcase
  end

  assign pc_en         = ctrl.pc_en;
  assign pc_sel_branch = ctrl.pc_sel_branch;
  assign if_id_en      = ctrl.if_id_en;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_en      = ctrl.id_ex_en;
  assign id_ex_flush   = ctrl.id_ex_flush;
  assign ex_wb_en      = ctrl.ex_wb_en;
  assign ex_wb_flush   = ctrl.ex_wb_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      unique case (state)
        ST_INIT: begin
          if (init_cnt == INIT_LAST) begin
            state <= ST_RUN;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (mem_stall) begin
            wait_cnt <= WW'(1);
            // With a one-cycle timeout the first stalled cycle already expires.
            if (MEM_TIMEOUT <= 1) begin
              state   <= ST_MEM_ERR;
              mem_err <= 1'b1;
            end else begin
              state <= ST_MEM_WAIT;
            end
          end
        end
        ST_MEM_WAIT: begin
          // mem_ready is checked first so it beats a coincident timeout.
          if (mem_ready) begin
            state <= ST_RUN;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt >= WAIT_LAST) begin
              state   <= ST_MEM_ERR;
              mem_err <= 1'b1;
            end
          end
        end
        ST_MEM_ERR: state <= ST_MEM_ERR;
        default:    state <= ST_INIT;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Two instances share one stimulus stream: the default build and a CNT_W=4
//   build whose counters must saturate at 15. Expected outputs come from a
//   small behavioural model of the pipeline-control rules.
// ----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int AW    = 6;
  localparam int INITC = 3;
  localparam int TMO   = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] id_rs = '0, id_rt = '0, ex_rd = '0, wb_rd = '0;
  logic          id_use_rs = 1'b0, id_use_rt = 1'b0;
  logic          ex_wr = 1'b0, wb_wr = 1'b0;
  logic          ex_branch_taken = 1'b0, ex_mem_req = 1'b0, mem_ready = 1'b0;

  logic        pc_en, pc_sel_branch, if_id_en, if_id_flush;
  logic        id_ex_en, id_ex_flush, ex_wb_en, ex_wb_flush, mem_err;
  logic [15:0] stall_cnt, flush_cnt;

  logic       s_pc_en, s_pc_sel_branch, s_if_id_en, s_if_id_flush;
  logic       s_id_ex_en, s_id_ex_flush, s_ex_wb_en, s_ex_wb_flush, s_mem_err;
  logic [3:0] s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model: what the pipeline controller must be doing.
  int init_left;   // INIT cycles still to run
  bit waiting;     // a memory access is outstanding
  int waited;      // stalled cycles spent on that access so far
  bit err;         // watchdog has fired
  int stalls;
  int flushes;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(AW), .INIT_CYCLES(INITC), .MEM_TIMEOUT(TMO),
                     .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rd(ex_rd), .ex_wr(ex_wr),
    .ex_branch_taken(ex_branch_taken), .ex_mem_req(ex_mem_req),
    .mem_ready(mem_ready), .wb_rd(wb_rd), .wb_wr(wb_wr),
    .pc_en(pc_en), .pc_sel_branch(pc_sel_branch), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_wb_en(ex_wb_en), .ex_wb_flush(ex_wb_flush), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.REG_AW(AW), .INIT_CYCLES(INITC), .MEM_TIMEOUT(TMO),
                     .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rd(ex_rd), .ex_wr(ex_wr),
    .ex_branch_taken(ex_branch_taken), .ex_mem_req(ex_mem_req),
    .mem_ready(mem_ready), .wb_rd(wb_rd), .wb_wr(wb_wr),
    .pc_en(s_pc_en), .pc_sel_branch(s_pc_sel_branch), .if_id_en(s_if_id_en),
    .if_id_flush(s_if_id_flush), .id_ex_en(s_id_ex_en),
    .id_ex_flush(s_id_ex_flush), .ex_wb_en(s_ex_wb_en),
    .ex_wb_flush(s_ex_wb_flush), .mem_err(s_mem_err),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d at %0t", tag, observed,
             expected, $time);
    end
  endtask

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic model_reset();
    init_left = INITC;
    waiting   = 1'b0;
    waited    = 0;
    err       = 1'b0;
    stalls    = 0;
    flushes   = 0;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rd = '0; wb_rd = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; ex_wr = 1'b0; wb_wr = 1'b0;
    ex_branch_taken = 1'b0; ex_mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // One clock cycle: inputs are already set (just after a rising edge);
  // predict, compare mid-cycle, then advance the model across the next edge.
  task automatic tick();
    bit hz, frz, br;
    logic [7:0] e; // pc_en sel if_en if_fl id_en id_fl ex_en ex_fl
    hz = (id_use_rs && ((ex_wr && ex_rd == id_rs) || (wb_wr && wb_rd == id_rs))) ||
         (id_use_rt && ((ex_wr && ex_rd == id_rt) || (wb_wr && wb_rd == id_rt)));
    br  = ex_branch_taken;
    frz = 1'b0;
    if (!rst_n || init_left > 0) e = 8'b0011_1111;
    else if (err)                e = 8'b0000_0000;
    else begin
      frz = waiting ? !mem_ready : (ex_mem_req && !mem_ready);
      if (frz)     e = 8'b0000_0011;
      else if (br) e = 8'b1111_1110;
      else if (hz) e = 8'b0000_1110;
      else         e = 8'b1010_1010;
    end
    #3;
    check("pc_en",         pc_en,         e[7]);
    check("pc_sel_branch", pc_sel_branch, e[6]);
    check("if_id_en",      if_id_en,      e[5]);
    check("if_id_flush",   if_id_flush,   e[4]);
    check("id_ex_en",      id_ex_en,      e[3]);
    check("id_ex_flush",   id_ex_flush,   e[2]);
    check("ex_wb_en",      ex_wb_en,      e[1]);
    check("ex_wb_flush",   ex_wb_flush,   e[0]);
    check("mem_err",       mem_err,       err);
    check("stall_cnt",     stall_cnt,     sat(stalls, 65535));
    check("flush_cnt",     flush_cnt,     sat(flushes, 65535));
    check("sat_stall_cnt", s_stall_cnt,   sat(stalls, 15));
    check("sat_flush_cnt", s_flush_cnt,   sat(flushes, 15));
    @(posedge clk);
    if (rst_n) begin
      if (init_left > 0) init_left--;
      else if (!err) begin
        if (frz) begin
          stalls++;
          waited  = waiting ? waited + 1 : 1;
          waiting = 1'b1;
          if (waited >= TMO) begin
            err     = 1'b1;
            waiting = 1'b0;
          end
        end else begin
          waiting = 1'b0;
          if (br)      flushes++;
          else if (hz) stalls++;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    model_reset();
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    clear_inputs();
    @(posedge clk); #1;

    // Reset and power-up purge.
    do_reset(2);
    repeat (INITC) tick();
    tick();                         // first RUN cycle, normal flow
    check("run_pc_en", pc_en, 1'b1);

    // RAW hazard against EX, then against WB, then with rs unused.
    id_rs = 6'd5; id_use_rs = 1'b1; ex_rd = 6'd5; ex_wr = 1'b1;
    tick();
    check("hazard_ex_stall_cnt", stall_cnt, 16'd1);
    clear_inputs();
    id_rs = 6'd5; id_use_rs = 1'b1; wb_rd = 6'd5; wb_wr = 1'b1;
    tick();
    clear_inputs();
    id_rs = 6'd5; id_use_rs = 1'b0; ex_rd = 6'd5; ex_wr = 1'b1;
    tick();
    clear_inputs();
    id_rt = 6'd9; id_use_rt = 1'b1; wb_rd = 6'd9; wb_wr = 1'b1;
    tick();

    // Branch beats a simultaneous hazard.
    clear_inputs();
    id_rs = 6'd7; id_use_rs = 1'b1; ex_rd = 6'd7; ex_wr = 1'b1;
    ex_branch_taken = 1'b1;
    tick();
    check("branch_flush_cnt", flush_cnt, 16'd1);
    check("branch_stall_cnt", stall_cnt, 16'd3);

    // Four-cycle memory access, then completion.
    clear_inputs();
    ex_mem_req = 1'b1;
    repeat (4) tick();
    mem_ready = 1'b1;
    tick();
    check("memwait_stall_cnt", stall_cnt, 16'd7);
    clear_inputs();
    ex_mem_req = 1'b1; mem_ready = 1'b1;   // single-cycle access
    tick();

    // Watchdog: 15 stalled cycles, then frozen; late mem_ready ignored.
    clear_inputs();
    ex_mem_req = 1'b1;
    repeat (TMO) tick();
    check("watchdog_mem_err", mem_err, 1'b1);
    repeat (3) tick();
    mem_ready = 1'b1;
    repeat (2) tick();
    check("watchdog_frozen_pc", pc_en, 1'b0);

    // Reset clears the error and re-enters INIT.
    clear_inputs();
    do_reset(1);
    check("reset_clears_mem_err", mem_err, 1'b0);
    repeat (INITC + 1) tick();

    // Counter saturation on the 4-bit build.
    id_rs = 6'd3; id_use_rs = 1'b1; ex_rd = 6'd3; ex_wr = 1'b1;
    repeat (20) tick();
    check("sat_stall_stops_at_15", s_stall_cnt, 4'd15);
    check("wide_stall_keeps_going", stall_cnt, 16'd20);

    // Randomised traffic with occasional recovery resets.
    for (int i = 0; i < 600; i++) begin
      id_rs           = AW'($urandom_range(0, 3));
      id_rt           = AW'($urandom_range(0, 3));
      ex_rd           = AW'($urandom_range(0, 3));
      wb_rd           = AW'($urandom_range(0, 3));
      id_use_rs       = ($urandom_range(0, 1) == 0);
      id_use_rt       = ($urandom_range(0, 1) == 0);
      ex_wr           = ($urandom_range(0, 1) == 0);
      wb_wr           = ($urandom_range(0, 1) == 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      ex_mem_req      = ($urandom_range(0, 3) == 0);
      mem_ready       = (i >= 300 && i < 340) ? 1'b0 : ($urandom_range(0, 2) != 0);
      if ((err && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0)
        do_reset(1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
